// File: rtl/clk_rst_seq.sv
// Lock-qualified reset sequencer: debounces the synchronized CCC lock, then releases
// core, peripheral and application resets in order; any lock drop reasserts all three.
module clk_rst_seq #(
   parameter int LOCK_DEBOUNCE = 1024,
   parameter int STAGE_DELAY   = 64,
   parameter int SW_HOLD       = 16
) (
   input  logic       FAB_CLK,
   input  logic       RESET,
   input  logic       FAB_LOCK,
   input  logic       SW_RST_REQ,
   input  logic       CLR_STATUS,
   output logic [2:0] RST_OUT,
   output logic       READY,
   output logic       LOCK_LOST,
   output logic [7:0] LOSS_CNT
);

   localparam int REL_LEN = 3 * STAGE_DELAY;
   localparam int MAX_AB  = (LOCK_DEBOUNCE > REL_LEN) ? LOCK_DEBOUNCE : REL_LEN;
   localparam int CNT_MAX = (MAX_AB > SW_HOLD) ? MAX_AB : SW_HOLD;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DEB_LAST  = CW'(LOCK_DEBOUNCE - 1);
   localparam logic [CW-1:0] STG0_LAST = CW'(STAGE_DELAY - 1);
   localparam logic [CW-1:0] STG1_LAST = CW'(2 * STAGE_DELAY - 1);
   localparam logic [CW-1:0] STG2_LAST = CW'(3 * STAGE_DELAY - 1);
   localparam logic [CW-1:0] SW_LAST   = CW'(SW_HOLD - 1);

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_RELEASE   = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;
   localparam logic [1:0] ST_SW_RESET  = 2'd3;

   logic          lock_meta_q;
   logic          lock_s_q;
   logic [1:0]    state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [2:0]    rst_q,      rst_d;
   logic          ready_q,    ready_d;
   logic          lost_q,     lost_d;
   logic [7:0]    loss_cnt_q, loss_cnt_d;
   logic [7:0]    loss_base;

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= FAB_LOCK;
         lock_s_q    <= lock_meta_q;
      end
   end

   // A clear coinciding with a loss restarts the count from this loss.
   assign loss_base = CLR_STATUS ? 8'd0 : loss_cnt_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rst_d      = rst_q;
      ready_d    = ready_q;
      lost_d     = lost_q;
      loss_cnt_d = loss_cnt_q;

      if (CLR_STATUS) begin
         lost_d     = 1'b0;
         loss_cnt_d = 8'd0;
      end

      if (state_q != ST_WAIT_LOCK && !lock_s_q) begin
         state_d    = ST_WAIT_LOCK;
         cnt_d      = '0;
         rst_d      = 3'b111;
         ready_d    = 1'b0;
         lost_d     = 1'b1;
         loss_cnt_d = (loss_base == 8'hFF) ? loss_base : loss_base + 8'd1;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               rst_d   = 3'b111;
               ready_d = 1'b0;
               if (!lock_s_q) begin
                  cnt_d = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == STG0_LAST) rst_d[0] = 1'b0;
               if (cnt_q == STG1_LAST) rst_d[1] = 1'b0;
               if (cnt_q == STG2_LAST) begin
                  rst_d   = 3'b000;
                  ready_d = 1'b1;
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
            ST_RUN: begin
               rst_d   = 3'b000;
               ready_d = 1'b1;
               if (SW_RST_REQ) begin
                  state_d = ST_SW_RESET;
                  rst_d   = 3'b111;
                  ready_d = 1'b0;
                  cnt_d   = '0;
               end
            end
            ST_SW_RESET: begin
               rst_d   = 3'b111;
               ready_d = 1'b0;
               if (cnt_q == SW_LAST) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               rst_d   = 3'b111;
               ready_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         state_q    <= ST_WAIT_LOCK;
         cnt_q      <= '0;
         rst_q      <= 3'b111;
         ready_q    <= 1'b0;
         lost_q     <= 1'b0;
         loss_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rst_q      <= rst_d;
         ready_q    <= ready_d;
         lost_q     <= lost_d;
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign RST_OUT   = rst_q;
   assign READY     = ready_q;
   assign LOCK_LOST = lost_q;
   assign LOSS_CNT  = loss_cnt_q;

endmodule
